// File: rtl/approx_mul_pkg.sv
// Shared types, widths and the round-robin pick function for the
// arbitrated 8x8 exact / l=2 approximate multiplier.
package approx_mul_pkg;

    localparam int unsigned MUL_W    = 8;
    localparam int unsigned PROD_W   = 16;
    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned ID_MAX_W = 3;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mul_mode_t;

    typedef struct packed {
        logic [MUL_W-1:0]    x;
        logic [MUL_W-1:0]    y;
        logic [ID_MAX_W-1:0] id;
        mul_mode_t           mode;
    } s1_payload_t;

    typedef struct packed {
        logic [PROD_W-1:0]   z;
        logic [ID_MAX_W-1:0] id;
        mul_mode_t           mode;
    } s2_payload_t;

    typedef struct packed {
        logic                found;
        logic [ID_MAX_W-1:0] idx;
    } rr_pick_t;

    // Round-robin search starting at last+1; the descending scan lets the
    // nearest candidate overwrite farther ones, so no found-chain is needed.
    function automatic rr_pick_t rr_pick(
        input logic [NREQ_MAX-1:0] valid,
        input logic [ID_MAX_W-1:0] last,
        input int unsigned         nreq
    );
        rr_pick_t          pick;
        logic [ID_MAX_W:0] cand;
        pick = '0;
        for (int unsigned k = NREQ_MAX; k >= 1; k--) begin
            cand = {1'b0, last} + (ID_MAX_W+1)'(k);
            if (32'(cand) >= nreq) begin
                cand = cand - (ID_MAX_W+1)'(nreq);
            end
            if ((k <= nreq) && valid[cand[ID_MAX_W-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[ID_MAX_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/approx_mul8_l2.sv
// Combinational 8x8 unsigned multiplier: exact product or l=2
// partial-product-exchange approximation, selected per operation.
module approx_mul8_l2
    import approx_mul_pkg::*;
(
    input  logic [MUL_W-1:0]  x,
    input  logic [MUL_W-1:0]  y,
    input  logic              approx,
    output logic [PROD_W-1:0] z
);

    logic              w_a;
    logic              w_b;
    logic              w_c;
    logic [PROD_W-1:0] w_exact;
    logic [PROD_W-1:0] w_trunc;
    logic [PROD_W-1:0] w_approx;

    always_comb begin
        w_a      = y[7] & x[0];
        w_b      = y[6] & x[1];
        w_c      = y[7] & x[1];
        w_exact  = PROD_W'(x) * PROD_W'(y);
        w_trunc  = PROD_W'(y) * PROD_W'(x[7:2]);
        // a=b=1 deliberately over-counts; the sum cannot carry past bit 15
        w_approx = (w_trunc << 2)
                 + (PROD_W'(w_a | w_b) << 7)
                 + (PROD_W'(w_a & w_b) << 8)
                 + (PROD_W'(w_c) << 8);
        z        = approx ? w_approx : w_exact;
    end

endmodule

// File: rtl/approx_mul_arbiter.sv
// Round-robin arbiter plus two-stage pipeline sharing one multiplier among
// NREQ requesters, with a single backpressured response port.
module approx_mul_arbiter
    import approx_mul_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [MUL_W*NREQ-1:0] req_x,
    input  logic [MUL_W*NREQ-1:0] req_y,
    input  logic [NREQ-1:0]       req_approx,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [PROD_W-1:0]     rsp_z,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_approx
);

    logic                r_s1_valid;
    logic                r_s2_valid;
    s1_payload_t         r_s1;
    s2_payload_t         r_s2;
    logic [ID_MAX_W-1:0] r_last_grant;

    logic [NREQ_MAX-1:0] w_valid_ext;
    logic                w_adv2;
    logic                w_s1_move;
    logic                w_s1_open;
    logic                w_accept;
    rr_pick_t            w_pick;
    logic [MUL_W-1:0]    w_sel_x;
    logic [MUL_W-1:0]    w_sel_y;
    mul_mode_t           w_sel_mode;
    logic [PROD_W-1:0]   w_z;

    always_comb begin
        w_valid_ext              = '0;
        w_valid_ext[NREQ-1:0]    = req_valid;
        w_adv2                   = !r_s2_valid || rsp_ready;
        w_s1_move                = r_s1_valid && w_adv2;
        w_s1_open                = !r_s1_valid || w_adv2;
        w_pick                   = rr_pick(w_valid_ext, r_last_grant, NREQ);
        w_accept                 = rst_n && w_s1_open && w_pick.found;
    end

    always_comb begin
        req_ready  = '0;
        w_sel_x    = '0;
        w_sel_y    = '0;
        w_sel_mode = MODE_EXACT;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_pick.idx == ID_MAX_W'(i)) begin
                req_ready[i] = w_accept;
                w_sel_x      = req_x[MUL_W*i +: MUL_W];
                w_sel_y      = req_y[MUL_W*i +: MUL_W];
                w_sel_mode   = mul_mode_t'(req_approx[i]);
            end
        end
    end

    approx_mul8_l2 u_mul (
        .x      (r_s1.x),
        .y      (r_s1.y),
        .approx (r_s1.mode == MODE_APPROX),
        .z      (w_z)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_s1         <= '0;
            r_s2         <= '0;
            r_last_grant <= ID_MAX_W'(NREQ - 1);
        end else begin
            if (w_s1_move) begin
                r_s2_valid <= 1'b1;
                r_s2       <= '{z: w_z, id: r_s1.id, mode: r_s1.mode};
            end else if (rsp_ready) begin
                r_s2_valid <= 1'b0;
            end
            // S1 is refilled or emptied only when it can hand its entry on
            if (w_s1_open) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1         <= '{x: w_sel_x, y: w_sel_y, id: w_pick.idx, mode: w_sel_mode};
                    r_last_grant <= w_pick.idx;
                end
            end
        end
    end

    always_comb begin
        rsp_valid  = r_s2_valid;
        rsp_z      = r_s2.z;
        rsp_id     = r_s2.id[IDW-1:0];
        rsp_approx = (r_s2.mode == MODE_APPROX);
    end

    generate
        if (IDW < ID_MAX_W) begin : g_id_pad
            logic w_unused_id;
            assign w_unused_id = ^r_s2.id[ID_MAX_W-1:IDW];
        end
    endgenerate

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Scoreboard bench for approx_mul_arbiter: an abstract depth-2, one-edge
// latency queue model predicts grants and responses from arithmetic rules.
module tb_approx_mul_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_x;
    logic [8*NREQ-1:0] req_y;
    logic [NREQ-1:0]   req_approx;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_z;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_approx;

    approx_mul_arbiter #(.NREQ(NREQ)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_approx (req_approx),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_z      (rsp_z),
        .rsp_id     (rsp_id),
        .rsp_approx (rsp_approx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned z;
        int unsigned id;
        int unsigned ap;
        int unsigned acc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned m_last   = NREQ - 1;
    int unsigned edge_cnt = 0;
    int          m_acc_id = -1;
    int unsigned n_cmp    = 0;
    int unsigned n_bad    = 0;
    int unsigned op_x[NREQ];
    int unsigned op_y[NREQ];
    bit          op_ap[NREQ];

    function automatic int unsigned ref_mul(int unsigned x, int unsigned y, bit ap);
        int unsigned a, b, c;
        if (!ap) return (x * y) & 16'hffff;
        a = (y >> 7) & x & 1;
        b = (y >> 6) & (x >> 1) & 1;
        c = (y >> 7) & (x >> 1) & 1;
        return ((y * (x / 4)) * 4 + (a | b) * 128 + (a & b) * 256 + c * 256) & 16'hffff;
    endfunction

    function automatic int rr_winner(logic [NREQ-1:0] v, int unsigned last);
        for (int k = 1; k <= NREQ; k++) begin
            int unsigned i;
            i = (last + k) % NREQ;
            if (v[i]) return int'(i);
        end
        return -1;
    endfunction

    function automatic bit model_valid();
        return (exp_q.size() > 0) && (exp_q[0].acc < edge_cnt);
    endfunction

    function automatic int unsigned exp_ready();
        int w;
        if (!rst_n) return 0;
        if (!((exp_q.size() < 2) || rsp_ready)) return 0;
        w = rr_winner(req_valid, m_last);
        if (w < 0) return 0;
        return 1 << w;
    endfunction

    task automatic chk(string name, int unsigned act, int unsigned expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            logic [31:0] tx, ty;
            tx = op_x[i];
            ty = op_y[i];
            req_x[8*i +: 8] = tx[7:0];
            req_y[8*i +: 8] = ty[7:0];
            req_approx[i]   = op_ap[i];
        end
    endtask

    function automatic int unsigned rnd_op();
        int unsigned s;
        s = $urandom_range(0, 7);
        if (s == 0) return 255;
        if (s == 1) return 0;
        return $urandom_range(0, 255);
    endfunction

    task automatic new_ops(int i);
        op_x[i]  = rnd_op();
        op_y[i]  = rnd_op();
        op_ap[i] = $urandom_range(0, 1);
    endtask

    // Reference model: pops, arbitrates and queues expected results at each edge
    initial begin : model
        exp_t e;
        int   w;
        bit   pop, load;
        forever begin
            @(posedge clk);
            m_acc_id = -1;
            if (!rst_n) begin
                exp_q.delete();
                m_last = NREQ - 1;
            end else begin
                pop  = model_valid() && rsp_ready;
                load = (exp_q.size() < 2) || rsp_ready;
                w    = rr_winner(req_valid, m_last);
                if (pop) void'(exp_q.pop_front());
                if (w >= 0 && load) begin
                    e.z   = ref_mul(req_x[8*w +: 8], req_y[8*w +: 8], req_approx[w]);
                    e.id  = w;
                    e.ap  = req_approx[w];
                    e.acc = edge_cnt + 1;
                    exp_q.push_back(e);
                    m_last   = w;
                    m_acc_id = w;
                end
            end
            edge_cnt++;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            chk("req_ready", req_ready, exp_ready());
            chk("rsp_valid", rsp_valid, model_valid());
            if (rsp_valid && model_valid()) begin
                chk("rsp_z", rsp_z, exp_q[0].z);
                chk("rsp_id", rsp_id, exp_q[0].id);
                chk("rsp_approx", rsp_approx, exp_q[0].ap);
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        pack();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        pack();
        for (int k = 0; k < 10; k++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        @(negedge clk);
        chk("drain_idle", rsp_valid, 0);
        step();
    endtask

    task automatic single(int id, int unsigned x, int unsigned y, bit ap, int unsigned ez);
        int unsigned cnt;
        op_x[id]  = x;
        op_y[id]  = y;
        op_ap[id] = ap;
        req_valid = '0;
        req_valid[id] = 1'b1;
        rsp_ready = 1'b1;
        pack();
        step();
        req_valid = '0;
        cnt = 0;
        while (cnt < 8) begin
            @(negedge clk);
            cnt++;
            if (rsp_valid) break;
        end
        chk("single_latency", cnt, 2);
        chk("single_z", rsp_z, ez);
        chk("single_id", rsp_id, id);
        chk("single_approx", rsp_approx, ap);
        step();
    endtask

    initial begin : stimulus
        int unsigned acc, held, rr_rsp;
        rst_n      = 1'b0;
        req_valid  = '0;
        rsp_ready  = 1'b0;
        req_x      = '0;
        req_y      = '0;
        req_approx = '0;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        pack();
        step();
        step();
        @(negedge clk);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_z", rsp_z, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_approx", rsp_approx, 0);
        step();
        rst_n = 1'b1;

        single(2, 255, 255, 1'b0, 65025);
        single(2, 255, 255, 1'b1, 64900);
        single(1, 3, 3, 1'b1, 0);
        single(3, 4, 5, 1'b1, 20);
        single(0, 2, 128, 1'b1, 256);

        // All requesters continuously valid: strict rotation, one result per cycle
        do_reset();
        rsp_ready = 1'b1;
        req_valid = '1;
        pack();
        rr_rsp = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rr_grant", req_ready, 1 << (k % NREQ));
            if (rsp_valid) begin
                chk("rr_rsp_id", rsp_id, rr_rsp % NREQ);
                rr_rsp++;
            end
            step();
            if (m_acc_id >= 0) begin
                new_ops(m_acc_id);
                pack();
            end
        end
        chk("rr_rsp_count", rr_rsp, 10);
        drain();

        // Backpressure for five cycles with everyone requesting
        rsp_ready = 1'b0;
        req_valid = '1;
        pack();
        acc  = 0;
        held = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (req_ready != '0) acc++;
            if (k >= 2) chk("stall_ready", req_ready, 0);
            if (k == 2) held = rsp_z;
            if (k > 2) chk("stall_z_hold", rsp_z, held);
            step();
            if (m_acc_id >= 0) begin
                new_ops(m_acc_id);
                pack();
            end
        end
        chk("stall_accepts", acc, 2);
        drain();

        // Reset while both stages hold results
        rsp_ready = 1'b0;
        req_valid = '1;
        pack();
        repeat (3) begin
            step();
            if (m_acc_id >= 0) begin
                new_ops(m_acc_id);
                pack();
            end
        end
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("full_rst_valid", rsp_valid, 0);
        chk("full_rst_z", rsp_z, 0);
        chk("full_rst_id", rsp_id, 0);
        chk("full_rst_approx", rsp_approx, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", req_ready, 1);
        drain();

        for (int c = 0; c < 1500; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (m_acc_id == i || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 60);
                    new_ops(i);
                end else if ($urandom_range(0, 99) < 5) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
            pack();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
